// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial UART transmitter (start bit, D_W data bits LSB first, stop bit)
//
// Purpose:
//   Accepts a D_W-bit word through a start/busy handshake and shifts it out as
//   one frame on tx_data. Bit timing comes from an external baud tick
//   generator, which this block enables through baud_en for the duration of
//   a frame. Every bit lasts B_TICK baud ticks.
//
// Parameters:
//   D_W     data word width in bits (>= 2)
//   B_TICK  baud ticks per bit period (>= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   baud_clk  in   one-clk-wide baud tick enable from the tick generator
//   in_data   in   word to send, sampled only when a start is accepted
//   tx_start  in   request to send in_data (ignored unless idle)
//   tx_data   out  serial line, idle high
//   baud_en   out  runs the baud tick generator while a frame is in flight
//   tx_busy   out  high from the cycle after acceptance to the end of stop
//   tx_done   out  one-clk pulse when a frame completes

module uart_tx #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_clk,
  input  logic [D_W-1:0] in_data,
  input  logic           tx_start,
  output logic           tx_data,
  output logic           baud_en,
  output logic           tx_busy,
  output logic           tx_done
);

  // Counter widths; guarded so a degenerate parameter never yields a 0-bit vector.
  localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;

  // Terminal values fit exactly in TW/BW bits even for power-of-two
  // parameters, so the compare never needs a wider counter.
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tick_q,  tick_d;
  logic [BW-1:0]  bit_q,   bit_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic           tx_data_q, tx_data_d;
  logic           baud_en_q, baud_en_d;
  logic           busy_q,    busy_d;
  logic           done_q,    done_d;

  logic tick_last;
  logic bit_last;

  assign tick_last = (tick_q == TICK_LAST);
  assign bit_last  = (bit_q == BIT_LAST);

  // State and all output registers; outputs never see inputs combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_data_q <= 1'b1;
      baud_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
      baud_en_q <= baud_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic. Every target holds its value unless a
  // baud tick or an accepted start moves it; tx_done defaults low so it can
  // only ever be a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    baud_en_d = baud_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_data_d = 1'b1;
        busy_d    = 1'b0;
        baud_en_d = 1'b0;
        // The start bit goes on the line in the same edge that accepts the
        // word, so acceptance latency is a single clock.
        if (tx_start) begin
          shift_d   = in_data;
          tick_d    = '0;
          bit_d     = '0;
          baud_en_d = 1'b1;
          busy_d    = 1'b1;
          tx_data_d = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        if (baud_clk) begin
          if (tick_last) begin
            tick_d    = '0;
            tx_data_d = shift_q[0];
            state_d   = DATA;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      DATA: begin
        if (baud_clk) begin
          if (tick_last) begin
            tick_d = '0;
            if (bit_last) begin
              tx_data_d = 1'b1;
              state_d   = STOP;
            end else begin
              // The next bit is shift_q[1]; drive it now so the line changes
              // on the same edge the register shifts.
              shift_d   = {1'b0, shift_q[D_W-1:1]};
              tx_data_d = shift_q[1];
              bit_d     = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      STOP: begin
        if (baud_clk) begin
          if (tick_last) begin
            tick_d    = '0;
            baud_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data = tx_data_q;
  assign baud_en = baud_en_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line-decoding receiver model
module tb_uart_tx;

  localparam int D_W    = 8;
  localparam int B_TICK = 16;
  localparam int FRAME  = (D_W + 2) * B_TICK;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_clk;
  logic [7:0] in_data;
  logic       tx_start;
  logic       tx_data;
  logic       baud_en;
  logic       tx_busy;
  logic       tx_done;

  int n_asrt = 0;
  int n_fail = 0;

  bit sparse   = 1'b0;
  int bit_clks = B_TICK;

  // Scoreboard: expected words pushed at stimulus time, decoded frames
  // ({stop, data}) pushed by the receiver model.
  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];

  // Line run-length / tick-alignment monitor state
  bit   align_on  = 1'b0;
  int   misalign  = 0;
  int   runs[$];
  int   run_len   = 0;
  logic prev_tx   = 1'b1;
  logic prev_baud = 1'b1;
  logic prev_busy = 1'b0;

  uart_tx #(.D_W(D_W), .B_TICK(B_TICK)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_clk (baud_clk),
    .in_data  (in_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .baud_en  (baud_en),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // Baud tick source: continuous, or one pulse every 4 clks in sparse mode.
  initial begin : baud_gen
    int ph;
    ph = 0;
    baud_clk = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (sparse) begin
        ph = (ph + 1) % 4;
        baud_clk = (ph == 0);
      end else begin
        baud_clk = 1'b1;
      end
    end
  end

  // Receiver model: on the first low sample, step to mid start bit, then
  // sample each following bit at its centre.
  initial begin : rx_model
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (!rst && tx_data === 1'b0) begin
        repeat (bit_clks / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          b[i] = tx_data;
        end
        repeat (bit_clks) @(negedge clk);
        stop_bit = tx_data;
        rx_q.push_back({stop_bit, b});
      end
    end
  end

  // A line transition while busy must come from an edge that saw baud_clk=1.
  initial begin : line_mon
    forever begin
      @(negedge clk);
      if (align_on) begin
        if (tx_data !== prev_tx) begin
          runs.push_back(run_len);
          run_len = 1;
          if (prev_busy && !prev_baud) misalign++;
        end else begin
          run_len++;
        end
      end else begin
        run_len = 0;
      end
      prev_tx   = tx_data;
      prev_baud = baud_clk;
      prev_busy = tx_busy;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_done !== 1'b1 && w < max_cycles);
    chk({tag, "_done_seen"}, tx_done, 1'b1);
  endtask

  task automatic check_rx(input string tag);
    int w;
    logic [8:0] got;
    logic [7:0] e;
    w = 0;
    while (rx_q.size() == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rx_present"}, rx_q.size() != 0, 1'b1);
    if (rx_q.size() != 0 && exp_q.size() != 0) begin
      got = rx_q.pop_front();
      e   = exp_q.pop_front();
      chk({tag, "_byte"}, got[7:0], e);
      chk({tag, "_stop"}, got[8], 1'b1);
    end
  endtask

  // Full cycle-by-cycle check of one frame under continuous baud ticks.
  task automatic frame_check(input logic [7:0] b, input string tag);
    int   line_bad;
    int   ctl_bad;
    int   k;
    logic e;
    @(negedge clk);
    in_data  = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
    in_data  = ~b;
    line_bad = 0;
    ctl_bad  = 0;
    for (int c = 0; c < FRAME; c++) begin
      k = c / B_TICK;
      if (k == 0)      e = 1'b0;
      else if (k <= 8) e = b[k-1];
      else             e = 1'b1;
      if (tx_data !== e) line_bad++;
      if (tx_busy !== 1'b1 || baud_en !== 1'b1 || tx_done !== 1'b0) ctl_bad++;
      if (c % B_TICK == B_TICK - 1) begin
        chk($sformatf("%s_bit%0d_line", tag, k), line_bad, 0);
        line_bad = 0;
      end
      @(negedge clk);
    end
    chk({tag, "_ctl_during_frame"}, ctl_bad, 0);
    chk({tag, "_done_cycle"}, {tx_data, baud_en, tx_busy, tx_done}, 4'b1001);
    @(negedge clk);
    chk({tag, "_after_done"}, {tx_data, baud_en, tx_busy, tx_done}, 4'b1000);
    check_rx(tag);
  endtask

  initial begin : main
    int busy_cnt;
    int done_cnt;
    int r2;
    int r3;

    rst      = 1'b1;
    tx_start = 1'b1;
    in_data  = 8'h77;

    // Reset held 3 clks with tx_start high
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {tx_data, baud_en, tx_busy, tx_done}, 4'b1000);
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {tx_data, baud_en, tx_busy, tx_done}, 4'b1000);

    // Basic frame, continuous ticks
    frame_check(8'hA5, "basic");

    // Sparse ticks: 8'h3C -> line 0 0 0 | 1 1 1 1 | 0 0 | 1
    repeat (4) @(negedge clk);
    sparse   = 1'b1;
    bit_clks = 4 * B_TICK;
    repeat (8) @(negedge clk);
    runs.delete();
    misalign = 0;
    align_on = 1'b1;
    in_data  = 8'h3C;
    tx_start = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("sparse", 2000);
    align_on = 1'b0;
    check_rx("sparse");
    r2 = (runs.size() > 2) ? runs[2] : -1;
    r3 = (runs.size() > 3) ? runs[3] : -1;
    chk("sparse_high_run_4bits", r2, 4 * 4 * B_TICK);
    chk("sparse_low_run_2bits", r3, 2 * 4 * B_TICK);
    chk("sparse_tick_alignment", misalign, 0);
    sparse   = 1'b0;
    bit_clks = B_TICK;
    repeat (8) @(negedge clk);

    // tx_start during a frame is ignored and not queued
    in_data  = 8'hFF;
    tx_start = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    in_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("busy_ignore", 500);
    check_rx("busy_ignore");
    busy_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) busy_cnt++;
    end
    chk("busy_ignore_no_second_frame", busy_cnt, 0);
    chk("busy_ignore_no_rx", rx_q.size(), 0);

    // Back-to-back frames with tx_start held high
    in_data  = 8'h01;
    tx_start = 1'b1;
    exp_q.push_back(8'h01);
    wait_done("b2b_first", 500);
    chk("b2b_done_cycle_line_high", tx_data, 1'b1);
    in_data = 8'h80;
    exp_q.push_back(8'h80);
    @(negedge clk);
    tx_start = 1'b0;
    chk("b2b_start_next_clk", {tx_data, tx_busy, baud_en}, 3'b011);
    wait_done("b2b_second", 500);
    check_rx("b2b_1");
    check_rx("b2b_2");

    // Reset during data bit 3
    repeat (4) @(negedge clk);
    in_data  = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat ((1 + 3) * B_TICK + 5) @(negedge clk);
    chk("midrst_frame_active", tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {tx_data, baud_en, tx_busy, tx_done}, 4'b1000);
    rst = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) busy_cnt++;
      if (tx_done !== 1'b0) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_stays_idle", busy_cnt, 0);
    rx_q.delete();
    frame_check(8'h5A, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
